id_ex_forward_stage: RTL and testbench



---
 rtl/id_ex_forward_stage.sv | 166 ++++++++++++++++
 tb/tb_id_ex_forward_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_forward_stage.sv
// ID/EX pipeline register with EX-stage forwarding for the pipelined MIPS core.
// Captures the decoded operands and control, then feeds the ALU with operands
// forwarded from the MEM and WB stages. It also flags load-use hazards back to
// the stall logic.
module id_ex_forward_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [DATA_W-1:0] ReadData1D,
  input  logic [DATA_W-1:0] ReadData2D,
  input  logic [DATA_W-1:0] SignImmD,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RdD,
  input  logic [1:0]        ALUControlD,
  input  logic              ALUSrcD,
  input  logic              RegDstD,
  input  logic              RegWriteD,
  input  logic              MemWriteD,
  input  logic              MemtoRegD,
  input  logic              BranchD,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic              RegWriteM,
  input  logic [DATA_W-1:0] ResultW,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              RegWriteW,
  output logic [DATA_W-1:0] Operand1,
  output logic [DATA_W-1:0] Operand2,
  output logic [1:0]        ALUControlE,
  output logic [DATA_W-1:0] WriteDataE,
  output logic [REG_AW-1:0] WriteRegE,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              MemtoRegE,
  output logic              BranchE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              LoadUseHazard
);

  // Source that a forwarding mux selects for an EX operand.
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // Everything carried across the ID/EX boundary. An all-zero value is a bubble.
  typedef struct packed {
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [1:0]        alu_ctrl;
    logic              alu_src;
    logic              reg_dst;
    logic              reg_write;
    logic              mem_write;
    logic              mem_to_reg;
    logic              branch;
  } id_ex_t;

  id_ex_t   id_ex_in;
  id_ex_t   id_ex_d;
  id_ex_t   id_ex_q;
  fwd_sel_e fwd_a;
  fwd_sel_e fwd_b;

  // Picks the youngest in-flight producer of src. Register 0 is hard-wired,
  // so a write to it is never forwarded.
  function automatic fwd_sel_e fwd_select(
    input logic [REG_AW-1:0] src,
    input logic              wr_m,
    input logic [REG_AW-1:0] reg_m,
    input logic              wr_w,
    input logic [REG_AW-1:0] reg_w
  );
    if (wr_m && (reg_m != '0) && (reg_m == src)) begin
      return FWD_MEM;
    end
    if (wr_w && (reg_w != '0) && (reg_w == src)) begin
      return FWD_WB;
    end
    return FWD_REG;
  endfunction

  assign id_ex_in = '{
    rd1:        ReadData1D,
    rd2:        ReadData2D,
    imm:        SignImmD,
    rs:         RsD,
    rt:         RtD,
    rd:         RdD,
    alu_ctrl:   ALUControlD,
    alu_src:    ALUSrcD,
    reg_dst:    RegDstD,
    reg_write:  RegWriteD,
    mem_write:  MemWriteD,
    mem_to_reg: MemtoRegD,
    branch:     BranchD
  };

  // Next ID/EX contents: a bubble on Flush, hold on Stall, otherwise load.
  always_comb begin
    // NOTE: default first so every path assigns id_ex_d; a missing branch would infer a latch.
    id_ex_d = id_ex_q;
    if (Flush) begin
      id_ex_d = '0;
    end else if (!Stall) begin
      id_ex_d = id_ex_in;
    end
  end

  // ID/EX register; reset clears it at once and drops the in-flight instruction.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  // Forwarding selects and the operand muxes they drive.
  always_comb begin
    fwd_a = fwd_select(id_ex_q.rs, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
    fwd_b = fwd_select(id_ex_q.rt, RegWriteM, WriteRegM, RegWriteW, WriteRegW);

    Operand1 = id_ex_q.rd1;
    case (fwd_a)
      FWD_MEM: Operand1 = ALUResultM;
      FWD_WB:  Operand1 = ResultW;
      default: Operand1 = id_ex_q.rd1;
    endcase

    WriteDataE = id_ex_q.rd2;
    case (fwd_b)
      FWD_MEM: WriteDataE = ALUResultM;
      FWD_WB:  WriteDataE = ResultW;
      default: WriteDataE = id_ex_q.rd2;
    endcase

    Operand2 = id_ex_q.alu_src ? id_ex_q.imm : WriteDataE;
  end

  assign ForwardAE     = fwd_a;
  assign ForwardBE     = fwd_b;
  assign ALUControlE   = id_ex_q.alu_ctrl;
  assign WriteRegE     = id_ex_q.reg_dst ? id_ex_q.rd : id_ex_q.rt;
  assign RegWriteE     = id_ex_q.reg_write;
  assign MemWriteE     = id_ex_q.mem_write;
  assign MemtoRegE     = id_ex_q.mem_to_reg;
  assign BranchE       = id_ex_q.branch;
  // A load in EX whose target is read by the instruction in ID. RtE==0 is
  // still flagged; the hazard unit masks that case.
  assign LoadUseHazard = id_ex_q.mem_to_reg &&
                         ((id_ex_q.rt == RsD) || (id_ex_q.rt == RtD));

endmodule

// File: tb/tb_id_ex_forward_stage.sv
// Self-checking bench for id_ex_forward_stage: directed steps and a random run,
// compared against a behavioural model of the pipeline register and hazard rules.
module tb_id_ex_forward_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              Stall, Flush;
  logic [DATA_W-1:0] ReadData1D, ReadData2D, SignImmD;
  logic [REG_AW-1:0] RsD, RtD, RdD;
  logic [1:0]        ALUControlD;
  logic              ALUSrcD, RegDstD, RegWriteD, MemWriteD, MemtoRegD, BranchD;
  logic [DATA_W-1:0] ALUResultM;
  logic [REG_AW-1:0] WriteRegM;
  logic              RegWriteM;
  logic [DATA_W-1:0] ResultW;
  logic [REG_AW-1:0] WriteRegW;
  logic              RegWriteW;
  logic [DATA_W-1:0] Operand1, Operand2, WriteDataE;
  logic [1:0]        ALUControlE;
  logic [REG_AW-1:0] WriteRegE;
  logic              RegWriteE, MemWriteE, MemtoRegE, BranchE;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              LoadUseHazard;

  int checks = 0;
  int errors = 0;

  // Model of the instruction currently held in EX.
  logic [DATA_W-1:0] m_rd1, m_rd2, m_imm;
  logic [REG_AW-1:0] m_rs, m_rt, m_rd;
  logic [1:0]        m_alu;
  logic              m_alusrc, m_regdst, m_rw, m_mw, m_m2r, m_br;

  always #5 clk = ~clk;

  id_ex_forward_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush),
    .ReadData1D(ReadData1D), .ReadData2D(ReadData2D), .SignImmD(SignImmD),
    .RsD(RsD), .RtD(RtD), .RdD(RdD), .ALUControlD(ALUControlD),
    .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .RegWriteD(RegWriteD),
    .MemWriteD(MemWriteD), .MemtoRegD(MemtoRegD), .BranchD(BranchD),
    .ALUResultM(ALUResultM), .WriteRegM(WriteRegM), .RegWriteM(RegWriteM),
    .ResultW(ResultW), .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .Operand1(Operand1), .Operand2(Operand2), .ALUControlE(ALUControlE),
    .WriteDataE(WriteDataE), .WriteRegE(WriteRegE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE), .BranchE(BranchE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .LoadUseHazard(LoadUseHazard)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    {m_rd1, m_rd2, m_imm} = '0;
    {m_rs, m_rt, m_rd} = '0;
    m_alu = 2'b00;
    {m_alusrc, m_regdst, m_rw, m_mw, m_m2r, m_br} = '0;
  endtask

  // Applies one rising edge to the model using the inputs the DUT just sampled.
  task automatic model_clock();
    if (Flush) begin
      model_reset();
    end else if (!Stall) begin
      m_rd1 = ReadData1D; m_rd2 = ReadData2D; m_imm = SignImmD;
      m_rs = RsD; m_rt = RtD; m_rd = RdD; m_alu = ALUControlD;
      m_alusrc = ALUSrcD; m_regdst = RegDstD; m_rw = RegWriteD;
      m_mw = MemWriteD; m_m2r = MemtoRegD; m_br = BranchD;
    end
  endtask

  // Which stage supplies register idx: 2 = MEM, 1 = WB, 0 = register file.
  function automatic logic [1:0] exp_fwd(input logic [REG_AW-1:0] idx);
    if (idx == 0) return 2'd0;
    if (RegWriteM && WriteRegM == idx) return 2'd2;
    if (RegWriteW && WriteRegW == idx) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [DATA_W-1:0] exp_value(input logic [1:0] sel,
                                                   input logic [DATA_W-1:0] regval);
    return (sel == 2'd2) ? ALUResultM : (sel == 2'd1) ? ResultW : regval;
  endfunction

  task automatic check_all(input string ctx);
    logic [1:0]        fa, fb;
    logic [DATA_W-1:0] wd;
    fa = exp_fwd(m_rs);
    fb = exp_fwd(m_rt);
    wd = exp_value(fb, m_rd2);
    check({ctx, ".ForwardAE"}, 32'(ForwardAE), 32'(fa));
    check({ctx, ".ForwardBE"}, 32'(ForwardBE), 32'(fb));
    check({ctx, ".Operand1"}, Operand1, exp_value(fa, m_rd1));
    check({ctx, ".WriteDataE"}, WriteDataE, wd);
    check({ctx, ".Operand2"}, Operand2, m_alusrc ? m_imm : wd);
    check({ctx, ".ALUControlE"}, 32'(ALUControlE), 32'(m_alu));
    check({ctx, ".WriteRegE"}, 32'(WriteRegE), 32'(m_regdst ? m_rd : m_rt));
    check({ctx, ".ctrl"}, {28'd0, RegWriteE, MemWriteE, MemtoRegE, BranchE},
          {28'd0, m_rw, m_mw, m_m2r, m_br});
    check({ctx, ".LoadUseHazard"}, 32'(LoadUseHazard),
          32'(m_m2r && (m_rt == RsD || m_rt == RtD)));
  endtask

  task automatic clear_inputs();
    {Stall, Flush} = '0;
    {ReadData1D, ReadData2D, SignImmD} = '0;
    {RsD, RtD, RdD} = '0;
    ALUControlD = 2'b00;
    {ALUSrcD, RegDstD, RegWriteD, MemWriteD, MemtoRegD, BranchD} = '0;
    {ALUResultM, ResultW} = '0;
    {WriteRegM, WriteRegW} = '0;
    {RegWriteM, RegWriteW} = '0;
  endtask

  task automatic randomize_inputs();
    ReadData1D = $urandom; ReadData2D = $urandom; SignImmD = $urandom;
    RsD = REG_AW'($urandom_range(0, 7));
    RtD = REG_AW'($urandom_range(0, 7));
    RdD = REG_AW'($urandom_range(0, 7));
    ALUControlD = 2'($urandom);
    {ALUSrcD, RegDstD, RegWriteD, MemWriteD, MemtoRegD, BranchD} = 6'($urandom);
    ALUResultM = $urandom; ResultW = $urandom;
    WriteRegM = REG_AW'($urandom_range(0, 7));
    WriteRegW = REG_AW'($urandom_range(0, 7));
    RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
    Flush = ($urandom_range(0, 9) == 0);
    Stall = ($urandom_range(0, 4) == 0);
  endtask

  // One rising edge for DUT and model, then settle just past the edge.
  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  initial begin
    logic [DATA_W-1:0] held_op1;
    logic [REG_AW-1:0] held_wreg;

    clear_inputs();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");

    // Load a busy instruction, then reset between edges.
    rst = 1'b0;
    randomize_inputs();
    {Stall, Flush} = '0;
    RegWriteD = 1'b1; MemtoRegD = 1'b1; BranchD = 1'b1; RsD = 5'd3;
    tick();
    check_all("preload");
    @(negedge clk);
    #1 rst = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    check("async_reset.Operand1", Operand1, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();

    // Plain load.
    ReadData1D = 32'd5; ReadData2D = 32'd7; ALUControlD = 2'b10;
    RsD = 5'd1; RtD = 5'd2;
    tick();
    check("load.Operand1", Operand1, 32'd5);
    check("load.Operand2", Operand2, 32'd7);
    check("load.ALUControlE", 32'(ALUControlE), 32'd2);
    check_all("load");

    // MEM beats WB for the same register.
    RsD = 5'd3; ReadData1D = 32'h0000_0011;
    tick();
    RegWriteM = 1'b1; WriteRegM = 5'd3; ALUResultM = 32'h1234;
    RegWriteW = 1'b1; WriteRegW = 5'd3; ResultW = 32'h9999;
    #1;
    check("memfwd.ForwardAE", 32'(ForwardAE), 32'd2);
    check("memfwd.Operand1", Operand1, 32'h1234);
    check_all("memfwd");

    // R0 is never forwarded.
    WriteRegM = 5'd0; RsD = 5'd0;
    tick();
    check("r0.ForwardAE", 32'(ForwardAE), 32'd0);
    check("r0.Operand1", Operand1, 32'h0000_0011);
    check_all("r0");

    // WB forwarding on rt with an immediate operand.
    RegWriteM = 1'b0;
    RtD = 5'd4; ALUSrcD = 1'b1; SignImmD = 32'hFFFF_FFF0; ReadData2D = 32'h55;
    RegWriteW = 1'b1; WriteRegW = 5'd4; ResultW = 32'hAA;
    tick();
    check("wbfwd.ForwardBE", 32'(ForwardBE), 32'd1);
    check("wbfwd.WriteDataE", WriteDataE, 32'hAA);
    check("wbfwd.Operand2", Operand2, 32'hFFFF_FFF0);
    check_all("wbfwd");

    // Load-use, followed by a flushed bubble.
    clear_inputs();
    MemtoRegD = 1'b1; RegWriteD = 1'b1; BranchD = 1'b1; MemWriteD = 1'b1;
    RtD = 5'd8; ALUControlD = 2'b11;
    tick();
    RsD = 5'd8; RtD = 5'd1; MemtoRegD = 1'b0;
    #1;
    check("loaduse.LoadUseHazard", 32'(LoadUseHazard), 32'd1);
    check_all("loaduse");
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check("flush.ctrl", {28'd0, RegWriteE, MemWriteE, MemtoRegE, BranchE}, 32'd0);
    check("flush.ALUControlE", 32'(ALUControlE), 32'd0);
    check_all("flush");

    // Stall holds, Flush overrides Stall.
    ReadData1D = 32'hCAFE; RsD = 5'd2; RegDstD = 1'b1; RdD = 5'd12;
    RegWriteD = 1'b1; ALUControlD = 2'b01;
    tick();
    held_op1 = Operand1; held_wreg = WriteRegE;
    Stall = 1'b1; ReadData1D = 32'hBEEF; RdD = 5'd13; ALUControlD = 2'b10;
    tick();
    check("stall.Operand1", Operand1, 32'hCAFE);
    check("stall.WriteRegE", 32'(WriteRegE), 32'd12);
    check_all("stall");
    Flush = 1'b1;
    tick();
    check("stallflush.ctrl", {28'd0, RegWriteE, MemWriteE, MemtoRegE, BranchE}, 32'd0);
    check("stallflush.Operand1", Operand1, 32'd0);
    check_all("stallflush");
    {Stall, Flush} = '0;

    // Destination select.
    RegDstD = 1'b1; RdD = 5'd9; RtD = 5'd6;
    tick();
    check("dst.rd", 32'(WriteRegE), 32'd9);
    RegDstD = 1'b0;
    tick();
    check("dst.rt", 32'(WriteRegE), 32'd6);

    // Random traffic: inputs change after each edge, checked before the next.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      #1;
      check_all("rand");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
